// File: rtl/hazard_stall_unit_if.sv
// Pipeline hazard control bundle: ID/EX/MEM hazard inputs and the stall/flush
// controls plus event counters returned by the hazard unit.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       IF_ID_opCode;
    logic [4:0]       IF_ID_rs;
    logic [4:0]       IF_ID_rt;
    logic             ID_EX_memRead;
    logic [4:0]       ID_EX_rt;
    logic             EX_MEM_branch;
    logic             EX_MEM_zero;

    logic             stallSignal;
    logic             pcWrite;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             EX_MEM_flush;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    modport master (
        output IF_ID_opCode, IF_ID_rs, IF_ID_rt, ID_EX_memRead, ID_EX_rt,
               EX_MEM_branch, EX_MEM_zero,
        input  stallSignal, pcWrite, IF_ID_write, IF_ID_flush, ID_EX_flush,
               EX_MEM_flush, stallCount, flushCount
    );

    modport slave (
        input  IF_ID_opCode, IF_ID_rs, IF_ID_rt, ID_EX_memRead, ID_EX_rt,
               EX_MEM_branch, EX_MEM_zero,
        output stallSignal, pcWrite, IF_ID_write, IF_ID_flush, ID_EX_flush,
               EX_MEM_flush, stallCount, flushCount
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use stall and taken-branch flush controller for a 5-stage pipeline,
// with saturating counters of issued stalls and flushes.
//
// state | meaning
// RUN   | normal issue; stalls and flushes may be raised
// STALL | one load-use bubble already inserted; loadUse ignored this cycle
// FLUSH | MEM was just flushed; branchTaken ignored, loadUse still honoured
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_unit_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rt_used;
    logic load_use;
    logic branch_taken;

    logic stall_sig;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;

    // lw (35) writes rt rather than reading it, so it never makes rt a source
    always_comb begin
        rt_used = 1'b0;
        case (hz.IF_ID_opCode)
            6'd0, 6'd43, 6'd4: rt_used = 1'b1;
            default:           rt_used = 1'b0;
        endcase
    end

    assign load_use = hz.ID_EX_memRead && (hz.ID_EX_rt != 5'd0) &&
                      ((hz.ID_EX_rt == hz.IF_ID_rs) ||
                       (rt_used && (hz.ID_EX_rt == hz.IF_ID_rt)));

    assign branch_taken = hz.EX_MEM_branch && hz.EX_MEM_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stall_sig    = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        case (state_q)
            RUN: begin
                if (branch_taken)  state_d = FLUSH;
                else if (load_use) state_d = STALL;
                else               state_d = RUN;
            end
            STALL: begin
                if (branch_taken) state_d = FLUSH;
                else              state_d = RUN;
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase

        // A taken branch squashes the younger instructions, so it beats a stall
        if (branch_taken && (state_q != FLUSH)) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (load_use && (state_q != STALL)) begin
            stall_sig   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end

        if (reset) begin
            stall_sig    = 1'b0;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_sig && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ex_mem_flush && !reset && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    assign hz.stallSignal  = stall_sig;
    assign hz.pcWrite      = pc_write;
    assign hz.IF_ID_write  = if_id_write;
    assign hz.IF_ID_flush  = if_id_flush;
    assign hz.ID_EX_flush  = id_ex_flush;
    assign hz.EX_MEM_flush = ex_mem_flush;
    assign hz.stallCount   = stall_cnt_q;
    assign hz.flushCount   = flush_cnt_q;

endmodule
